// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared experiment input types and channel indices
`timescale 1ns/1ps
package types_pkg;

  localparam int NUM_INPUT_CH       = 5;
  localparam int INPUT_FILTER_WIDTH = 16;

  localparam int CH_START          = 0;
  localparam int CH_FG_OPTO        = 1;
  localparam int CH_PHASE          = 2;
  localparam int CH_WIRE_SENSOR    = 3;
  localparam int CH_DETECTOR_READY = 4;

  typedef logic [NUM_INPUT_CH-1:0][INPUT_FILTER_WIDTH-1:0] filter_len_t;

  // Packed MSB first, so bit positions line up with the CH_* indices.
  typedef struct packed {
    logic detector_ready;
    logic wire_sensor;
    logic phase;
    logic fg_opto;
    logic start;
  } input_signals_t;

endpackage

// File: rtl/input_channel_filter.sv
// rtl/input_channel_filter.sv - one channel: synchronizer, persistence filter, edges, glitch flag
`timescale 1ns/1ps
module input_channel_filter
  import types_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   FILTER_WIDTH = INPUT_FILTER_WIDTH,
  parameter logic INV          = 1'b0,
  parameter logic RST_LVL      = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_signal,
  input  logic                    raw_i,
  input  logic [FILTER_WIDTH-1:0] len_i,
  input  logic                    clear_i,
  output logic                    level_o,
  output logic                    rise_o,
  output logic                    fall_o,
  output logic                    glitch_o
);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    f_q, f_d;
  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    glitch_q, glitch_d;
  logic                    s;
  logic [FILTER_WIDTH-1:0] limit;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i ^ INV};
  assign s      = sync_q[SYNC_STAGES-1];

  // A length of 0 is treated as 1, so the commit threshold L-1 bottoms out at 0.
  assign limit = (len_i == '0) ? '0 : len_i - {{(FILTER_WIDTH-1){1'b0}}, 1'b1};

  // Next-state: count while s disagrees with f, commit at the threshold, flag early returns.
  always_comb begin
    f_d      = f_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q & ~clear_i;
    if (s == f_q) begin
      cnt_d = '0;
      if (cnt_q != '0) begin
        glitch_d = 1'b1;
      end
    end else if (cnt_q < limit) begin
      cnt_d = cnt_q + {{(FILTER_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      f_d    = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end
  end

  // State registers; everything returns to the reset level with an idle counter.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      sync_q   <= {SYNC_STAGES{RST_LVL}};
      f_q      <= RST_LVL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      f_q      <= f_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign level_o  = f_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = glitch_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - conditions the five raw experiment inputs into clean levels
`timescale 1ns/1ps
module input_conditioner
  import types_pkg::*;
#(
  parameter int                      SYNC_STAGES  = 2,
  parameter int                      FILTER_WIDTH = INPUT_FILTER_WIDTH,
  parameter logic [NUM_INPUT_CH-1:0] INVERT       = 5'b00000,
  parameter logic [NUM_INPUT_CH-1:0] RESET_LEVEL  = 5'b00001
) (
  input  logic                                      clock,
  input  logic                                      reset_signal,
  input  logic [NUM_INPUT_CH-1:0]                   raw_in,
  input  logic [NUM_INPUT_CH-1:0][FILTER_WIDTH-1:0] filter_len,
  input  logic                                      clear_flags,
  output input_signals_t                            levels,
  output logic [NUM_INPUT_CH-1:0]                   rise,
  output logic [NUM_INPUT_CH-1:0]                   fall,
  output logic [NUM_INPUT_CH-1:0]                   glitch
);

  // SYNC_STAGES must stay within 2..4; fewer than 2 gives no metastability margin.
  logic [NUM_INPUT_CH-1:0] level_vec;

  for (genvar ch = 0; ch < NUM_INPUT_CH; ch++) begin : g_ch
    input_channel_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_WIDTH(FILTER_WIDTH),
      .INV         (INVERT[ch]),
      .RST_LVL     (RESET_LEVEL[ch])
    ) u_filter (
      .clock       (clock),
      .reset_signal(reset_signal),
      .raw_i       (raw_in[ch]),
      .len_i       (filter_len[ch]),
      .clear_i     (clear_flags),
      .level_o     (level_vec[ch]),
      .rise_o      (rise[ch]),
      .fall_o      (fall[ch]),
      .glitch_o    (glitch[ch])
    );
  end

  assign levels = input_signals_t'(level_vec);

endmodule
